// File: rtl/adder_meas_pkg.sv
// Shared types and helpers for the adder measurement readback block.
//   meas_state_t : measurement FSM states
//   DEF_*        : default widths for the window length and edge counter
//   count_max()  : all-ones value of a counter of the given width
package adder_meas_pkg;

    localparam int unsigned DEF_WINDOW_W = 16;
    localparam int unsigned DEF_COUNT_W  = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meas_state_t;

    // Saturation value for a counter 'width' bits wide (width <= 64).
    function automatic logic [63:0] count_max(input int unsigned width);
        return (64'(1) << width) - 64'(1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous signal into the clk domain and flags its rising edges.
//   clk        : sampling clock
//   reset_n    : synchronous active-low reset, clears the whole chain
//   sample_in  : asynchronous input
//   edge_pulse : registered 1-cycle pulse per rising edge,
//                SYNC_STAGES+1 cycles after the input change
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;
    logic                   s_last;

    assign s_last = sync_q[SYNC_STAGES-1];

    // Synchronizer chain, previous-value flop and registered edge detector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '0;
            s_prev     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sample_in};
            s_prev     <= s_last;
            edge_pulse <= s_last & ~s_prev;
        end
    end

endmodule

// File: rtl/adder_meas_counter.sv
// Counts rising edges of sample_in over a CPU-programmed window of clk cycles.
//   clk           : wishbone clock
//   reset_n       : synchronous active-low reset
//   start         : LA level; a rising edge requests a measurement
//   window_cycles : window length in cycles, captured on an accepted start
//   sample_in     : asynchronous signal under measurement
//   count         : edges counted in the last window (saturating)
//   busy          : measurement armed or running
//   done          : measurement complete, count/overflow valid
//   overflow      : sticky, an edge arrived while count was saturated
module adder_meas_counter
    import adder_meas_pkg::*;
#(
    parameter int unsigned WINDOW_W    = DEF_WINDOW_W,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window_cycles,
    input  logic                sample_in,
    output logic [COUNT_W-1:0]  count,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(count_max(COUNT_W));

    meas_state_t         state;
    logic [WINDOW_W-1:0] timer;
    logic                start_q;
    logic                start_pulse_c;
    logic                edge_pulse;

    assign start_pulse_c = start & ~start_q;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_in  (sample_in),
        .edge_pulse (edge_pulse)
    );

    // Measurement FSM; busy/done are registered alongside the state so they
    // line up with it cycle for cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            timer    <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_pulse_c) begin
                        state    <= ARM;
                        timer    <= window_cycles;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ARM: begin
                    // A zero-length window skips MEASURE entirely.
                    if (timer != '0) begin
                        state <= MEASURE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (edge_pulse) begin
                        if (count == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                    timer <= timer - WINDOW_W'(1);
                    if (timer == WINDOW_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_meas_counter.sv
// Self-checking bench for adder_meas_counter. Two instances share all inputs:
// one with the default 24-bit counter and one with a 4-bit counter so that
// saturation is exercised on every run.
module tb_adder_meas_counter;

    localparam int unsigned WW    = 16;
    localparam int unsigned SYNC  = 2;
    localparam int          LAT   = SYNC + 1;
    localparam int          MAXC  = 8192;
    localparam int          MAX24 = (1 << 24) - 1;
    localparam int          MAX4  = 15;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [WW-1:0] window_cycles;
    logic          sample_in;

    logic [23:0] count;
    logic        busy, done, overflow;
    logic [3:0]  count4;
    logic        busy4, done4, overflow4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ph     = 0;
    int mode   = 0;   // 0 low, 1 random, 2 toggle every 4 clk, 3 toggle every clk
    bit hist [0:MAXC-1];

    adder_meas_counter #(.WINDOW_W(WW), .COUNT_W(24), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .window_cycles(window_cycles),
        .sample_in(sample_in), .count(count), .busy(busy), .done(done), .overflow(overflow)
    );

    adder_meas_counter #(.WINDOW_W(WW), .COUNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .window_cycles(window_cycles),
        .sample_in(sample_in), .count(count4), .busy(busy4), .done(done4), .overflow(overflow4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle. hist[c] is the sample_in level held during cycle c.
    // A reset clears the synchronizer, which is equivalent to the most recent
    // SYNC+1 input levels having been 0.
    task automatic tick;
        if (cyc < MAXC) begin
            hist[cyc] = sample_in;
            if (!reset_n) begin
                for (int k = 0; k <= SYNC; k++) begin
                    if (cyc - k >= 0) hist[cyc-k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        ph++;
        case (mode)
            1:       sample_in = 1'($urandom % 2);
            2:       sample_in = ((ph / 4) % 2) != 0;
            3:       sample_in = ~sample_in;
            default: sample_in = 1'b0;
        endcase
    endtask

    // Reference: rising edges of the input seen LAT cycles late, counted over
    // the MEASURE cycles t+2 .. t+1+w, saturating at cmax.
    function automatic void model(input int t, input int w, input int cmax,
                                  output int cnt, output bit ov);
        cnt = 0;
        ov  = 1'b0;
        for (int c = t + 2; c <= t + 1 + w; c++) begin
            if (hist[c-LAT] && !hist[c-LAT-1]) begin
                if (cnt == cmax) ov = 1'b1;
                else             cnt++;
            end
        end
    endfunction

    task automatic chk_all(input string tag, input bit b, input bit d,
                           input int c24, input bit o24, input int c4, input bit o4);
        chk({tag, "_busy"},  32'(busy),      32'(b));
        chk({tag, "_done"},  32'(done),      32'(d));
        chk({tag, "_count"}, 32'(count),     32'(c24));
        chk({tag, "_ovf"},   32'(overflow),  32'(o24));
        chk({tag, "_busy4"}, 32'(busy4),     32'(b));
        chk({tag, "_done4"}, 32'(done4),     32'(d));
        chk({tag, "_cnt4"},  32'(count4),    32'(c4));
        chk({tag, "_ovf4"},  32'(overflow4), 32'(o4));
    endtask

    // One measurement of w cycles started by a rising start in the current
    // cycle. repulse_at (>0) raises start again at that offset; hold keeps
    // start high throughout. window_cycles is scrambled after acceptance.
    task automatic run(input string tag, input int w, input int repulse_at, input bit hold,
                       output int c24, output int c4);
        int t;
        bit o24, o4;
        window_cycles = WW'(w);
        start = 1'b1;
        t = cyc;
        tick;
        start = hold;
        window_cycles = WW'($urandom);
        chk({tag, "_arm_busy"}, 32'(busy), 32'(1));
        chk({tag, "_arm_done"}, 32'(done), 32'(0));
        chk({tag, "_arm_cnt"},  32'(count), 32'(0));
        while (cyc < t + 1 + w) begin
            start = hold || (repulse_at > 0 && cyc == t + repulse_at);
            tick;
            window_cycles = WW'($urandom);
        end
        chk({tag, "_last_busy"}, 32'(busy), 32'(1));
        chk({tag, "_last_done"}, 32'(done), 32'(0));
        start = hold;
        tick;
        model(t, w, MAX24, c24, o24);
        model(t, w, MAX4,  c4,  o4);
        chk_all({tag, "_end"}, 1'b0, 1'b1, c24, o24, c4, o4);
    endtask

    initial begin
        int c24, c4, w, t;

        reset_n       = 1'b0;
        start         = 1'b0;
        window_cycles = '0;
        sample_in     = 1'b0;
        for (int i = 0; i < MAXC; i++) hist[i] = 1'b0;
        repeat (3) tick;
        chk_all("reset", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick;

        // Slow square wave: one rising edge per 8 cycles over 800 cycles.
        mode = 2;
        repeat (10) tick;
        run("w800", 800, 0, 1'b0, c24, c4);
        assert (c24 >= 99 && c24 <= 101) else begin
            errors++;
            $error("FAIL w800_range: model=%0d required=100+-1", c24);
        end
        checks++;

        // Zero-length window: busy for the ARM cycle only.
        tick;
        run("w0", 0, 0, 1'b0, c24, c4);
        chk("w0_count_zero", 32'(count), 32'(0));

        // Maximum rate input saturates the 4-bit instance.
        mode = 3;
        repeat (5) tick;
        run("sat", 40, 0, 1'b0, c24, c4);
        chk("sat_cnt4", 32'(count4), 32'(15));
        chk("sat_ovf4", 32'(overflow4), 32'(1));
        chk("sat_cnt24", 32'(count), 32'(20));

        // Random input, random windows.
        mode = 1;
        for (int r = 0; r < 6; r++) begin
            tick;
            w = int'($urandom_range(1, 70));
            run($sformatf("rnd%0d", r), w, 0, 1'b0, c24, c4);
        end

        // Re-pulse mid-MEASURE is ignored; done arrives at the original cycle.
        tick;
        run("repulse", 100, 30, 1'b0, c24, c4);

        // Start held high across further windows: one run, done stays up.
        tick;
        run("hold", 30, 0, 1'b1, c24, c4);
        repeat (70) tick;
        chk("hold_busy",  32'(busy),  32'(0));
        chk("hold_done",  32'(done),  32'(1));
        chk("hold_count", 32'(count), 32'(c24));
        chk("hold_cnt4",  32'(count4), 32'(c4));
        start = 1'b0;
        tick;
        run("after_hold", 20, 0, 1'b0, c24, c4);

        // Reset mid-MEASURE with a simultaneous start edge.
        tick;
        window_cycles = WW'(200);
        start = 1'b1;
        t = cyc;
        tick;
        start = 1'b0;
        repeat (50) tick;
        chk("pre_rst_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        start   = 1'b1;
        tick;
        reset_n = 1'b1;
        start   = 1'b0;
        chk_all("rst_mid", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        tick;
        chk("rst_start_ign_busy", 32'(busy), 32'(0));
        chk("rst_start_ign_done", 32'(done), 32'(0));
        repeat (3) tick;
        run("post_rst", 25, 0, 1'b0, c24, c4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_meas_counter.md
# adder_meas_counter

Measurement readback block for the instrumented adder experiment. It counts rising edges of a project output signal over a CPU-programmed window of clock cycles and returns the count to the CPU on logic-analyzer outputs. Start, window length and status are carried on LA bits. It sits in the project wrapper beside the adder and is clocked from the Caravel wishbone clock.

## Interface

Parameters:
- WINDOW_W, 16: width of the window length, in clock cycles.
- COUNT_W, 24: width of the edge counter.
- SYNC_STAGES, 2: number of synchronizer flops on `sample_in`; minimum 2.

Ports:
- `clk` in 1: the single clock, driven from `wb_clk_i`.
- `reset_n` in 1: reset, synchronous and active-low.
- `start` in 1: level from the LA. A rising edge requests a measurement.
- `window_cycles` in WINDOW_W: measurement length in cycles. Sampled only on an accepted start.
- `sample_in` in 1: signal being measured. Asynchronous to `clk`.
- `count` out COUNT_W: edges counted. Valid while `done` is 1.
- `busy` out 1: high in ARM and in MEASURE.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky. Set when an edge arrives while `count` is at its maximum.

## Operation

- `start_pulse` = `start` & ~`start_q`. `start_q` is a registered copy of `start`; `start` is already in the `clk` domain.
- `sample_in` passes through a SYNC_STAGES flop chain, then a rising-edge detector: `edge` = `s_last` & ~`s_prev`.

State machine states: IDLE, ARM, MEASURE, DONE.
- IDLE or DONE, with `start_pulse`:
  - Next state ARM.
  - `count` <= 0, `overflow` <= 0.
  - `timer` <= `window_cycles`.
- ARM: lasts exactly 1 cycle. Next state is MEASURE if `timer` != 0, otherwise DONE.
- MEASURE:
  - Every cycle: if `edge`, then `count` <= `count` + 1.
  - `count` saturates at 2^COUNT_W−1. An edge while saturated sets `overflow`.
  - `timer` decrements every cycle. When `timer` == 1, next state is DONE.
  - MEASURE therefore lasts exactly `window_cycles` cycles.
- DONE: holds `count` and `overflow` until the next accepted start.

Boundary conditions:
- `start_pulse` in ARM or MEASURE: ignored, not queued.
- `start` held high: only one measurement runs.
- `window_cycles` changing during ARM or MEASURE: no effect.
- `window_cycles` = 0: 0 MEASURE cycles, `count` = 0.
- Edges are counted only in MEASURE cycles. Edges in ARM, DONE or IDLE are discarded.
- `reset_n` low, in any state:
  - Next cycle the state is IDLE.
  - `count`, `busy`, `done`, `overflow`, `timer` and `start_q` are all 0.
  - Synchronizer flops and `s_prev` are all 0.
  - Reset overrides a simultaneous `start_pulse`.
- Maximum countable rate is one edge per 2 `clk` cycles. Faster inputs alias.

## Timing

- Reset value of every output: 0.
- `start` rises at cycle t. ARM is cycle t+1. MEASURE is cycles t+2 … t+1+W.
- `done` = 1 at cycle t+2+W. For W = 0, `done` = 1 at cycle t+2.
- `busy` is high for cycles t+1 … t+1+W.
- `sample_in` to `edge` latency: SYNC_STAGES+1 cycles.

## Structure

- Package `adder_meas_pkg` contains:
  - the state enum (IDLE, ARM, MEASURE, DONE);
  - default widths WINDOW_W and COUNT_W;
  - the `COUNT_MAX` helper.
- Sub-module `edge_sync` holds the synchronizer chain plus the rising-edge detector. Parameter: SYNC_STAGES. Output: 1-cycle `edge` pulse.
- Top level holds the FSM, `timer`, counter and output registers.

## Test plan

- `sample_in` toggles every 4 `clk` (one rising edge per 8 cycles), W = 800, start pulse → after 802 cycles `done` = 1, `count` = 100 ±1, `overflow` = 0.
- W = 0, start → `busy` high for 1 cycle; `done` = 1 two cycles after `start` rises; `count` = 0.
- COUNT_W = 4, `sample_in` toggles every `clk`, W = 40 → `count` = 15, `overflow` = 1.
- `start` re-pulsed mid-MEASURE → ignored; `done` arrives at the original cycle. Start pulse after `done` → `count` and `overflow` clear, new run completes.
- `start` held high across two windows → only one run; `done` stays 1.
- `reset_n` low for 1 cycle mid-MEASURE → next cycle all outputs 0 and state IDLE. A start pulse in the same cycle as reset is ignored.
